prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 151 +++++++++++++++
 tb/tb_prog_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Serial program loader: fills instruction memory from a length-prefixed byte
// stream while holding the core in reset. Optional checksum byte via LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  if (ADDR_W < 8) begin : gAddrWidthCheck
    $error("prog_loader: ADDR_W must be at least 8 to hold 256 words");
  end

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} stateT;
`else
  typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERROR} stateT;
`endif

  stateT             state;
  logic [1:0]        byteCnt;
  logic [ADDR_W-1:0] wordIdx;
  logic [ADDR_W-1:0] lastIdx;
  logic [23:0]       wordAsm;
  logic              accept;
  logic              lastWord;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  // LEN byte 0 encodes 256 words, so the last index is simply LEN-1 modulo 256.
  function automatic logic [ADDR_W-1:0] lenToLastIdx(input logic [7:0] lenByte);
    logic [7:0] lenM1;
    lenM1 = lenByte - 8'd1;
    return ADDR_W'(lenM1);
  endfunction

  assign accept   = in_valid && in_ready;
  assign lastWord = (wordIdx == lastIdx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      byteCnt    <= '0;
      wordIdx    <= '0;
      lastIdx    <= '0;
      wordAsm    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LEN;
            in_ready <= 1'b1;
          end
        end
        LEN: begin
          if (accept) begin
            lastIdx <= lenToLastIdx(in_byte);
            wordIdx <= '0;
            byteCnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
            state   <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            csum    <= csum ^ in_byte;
`endif
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) begin
              // Word complete: strobe next cycle while still accepting bytes.
              imem_we    <= 1'b1;
              imem_addr  <= wordIdx;
              imem_wdata <= {wordAsm, in_byte};
              if (lastWord) begin
`ifdef LOADER_CHECKSUM_EN
                state    <= CSUM;
`else
                state    <= DONE;
                in_ready <= 1'b0;
`endif
              end else begin
                wordIdx <= wordIdx + ADDR_W'(1);
              end
            end else begin
              wordAsm <= {wordAsm[15:0], in_byte};
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            state    <= (in_byte == csum) ? DONE : ERROR;
          end
        end
`endif
        DONE: begin
          if (start) begin
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            in_ready <= 1'b1;
            state    <= LEN;
          end else begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
        ERROR: begin
          cpu_hold <= 1'b1;
          if (start) begin
            error    <= 1'b0;
            in_ready <= 1'b1;
            state    <= LEN;
          end else begin
            error    <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load sequences, flow control, reset mid-load, reload.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int weCount = 0;
  int lastWeCyc = -100;
  int doneCyc = -1;
  logic donePrev = 1'b0;
  logic [31:0] mem [0:255];
  int addrLog [0:511];
  logic [7:0] xorAcc;

  prog_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Strobe and done-edge recorder, sampled on the inactive edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      mem[imem_addr] = imem_wdata;
      if (weCount < 512) addrLog[weCount] = int'(imem_addr);
      weCount++;
      lastWeCyc = cyc;
    end
    if (done === 1'b1 && donePrev !== 1'b1) doneCyc = cyc;
    donePrev = done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic startPulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // gap: 0 = continuous, 1 = idle cycle after the byte, 2 = idle cycle with a stray start
  task automatic sendByte(input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (gap != 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = (gap == 2);
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      sendByte(w[31-8*k -: 8], gap);
      xorAcc = xorAcc ^ w[31-8*k -: 8];
    end
  endtask

  task automatic stopValid();
    @(negedge clk);
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  function automatic logic [31:0] bigWord(input int i);
    logic [7:0] v;
    v = 8'(i);
    return {v, ~v, 8'h5A, v ^ 8'h33};
  endfunction

  initial begin
    // Reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("idle_in_ready", in_ready, 0);

    // Basic two-word load, continuous valid
    weCount = 0;
    startPulse();
    #1 chk("len_in_ready", in_ready, 1);
    xorAcc = 8'h00;
    sendByte(8'h02, 0);
    sendWord(32'h20080005, 0);
    sendWord(32'h0000000C, 0);
`ifdef LOADER_CHECKSUM_EN
    sendByte(xorAcc, 0);
`endif
    stopValid();
    tick(4);
    chk("basic_strobes", weCount, 2);
    chk("basic_addr0", addrLog[0], 0);
    chk("basic_addr1", addrLog[1], 1);
    chk("basic_word0", mem[0], 32'h20080005);
    chk("basic_word1", mem[1], 32'h0000000C);
    chk("basic_done", done, 1);
    chk("basic_cpu_hold", cpu_hold, 0);
    chk("basic_error", error, 0);
    chk("basic_in_ready", in_ready, 0);
`ifndef LOADER_CHECKSUM_EN
    chk("basic_done_latency", doneCyc - lastWeCyc, 1);
`endif

    // Reload from DONE with one word
    weCount = 0;
    mem[0] = 32'h0;
    startPulse();
    #1;
    chk("reload_cpu_hold", cpu_hold, 1);
    chk("reload_done_clr", done, 0);
    xorAcc = 8'h00;
    sendByte(8'h01, 0);
    sendWord(32'hDEADBEEF, 0);
`ifdef LOADER_CHECKSUM_EN
    sendByte(xorAcc, 0);
`endif
    stopValid();
    tick(4);
    chk("reload_strobes", weCount, 1);
    chk("reload_addr", addrLog[0], 0);
    chk("reload_word", mem[0], 32'hDEADBEEF);
    chk("reload_done", done, 1);

    // Gapped valid, with a stray start that must be ignored mid-load
    weCount = 0;
    mem[0] = 32'h0;
    mem[1] = 32'h0;
    startPulse();
    xorAcc = 8'h00;
    sendByte(8'h02, 1);
    sendWord(32'h20080005, 2);
    sendWord(32'h0000000C, 1);
`ifdef LOADER_CHECKSUM_EN
    sendByte(xorAcc, 1);
`endif
    stopValid();
    tick(4);
    chk("gap_strobes", weCount, 2);
    chk("gap_word0", mem[0], 32'h20080005);
    chk("gap_word1", mem[1], 32'h0000000C);
    chk("gap_done", done, 1);

    // Maximum length: LEN=0 means 256 words
    weCount = 0;
    startPulse();
    xorAcc = 8'h00;
    sendByte(8'h00, 0);
    for (int i = 0; i < 256; i++) sendWord(bigWord(i), 0);
`ifdef LOADER_CHECKSUM_EN
    sendByte(xorAcc, 0);
`endif
    stopValid();
    tick(4);
    chk("big_strobes", weCount, 256);
    for (int i = 0; i < 256; i++) begin
      chk("big_addr", addrLog[i], i);
      chk("big_word", mem[i], bigWord(i));
    end
    chk("big_done", done, 1);
    chk("big_cpu_hold", cpu_hold, 0);

    // Reset after 6 payload bytes
    weCount = 0;
    mem[0] = 32'h0;
    mem[1] = 32'h0;
    startPulse();
    sendByte(8'h02, 0);
    sendWord(32'h11223344, 0);
    sendByte(8'h55, 0);
    sendByte(8'h66, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_strobes", weCount, 1);
    chk("midrst_word0", mem[0], 32'h11223344);
    chk("midrst_cpu_hold", cpu_hold, 1);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_imem_we", imem_we, 0);
    chk("midrst_addr", imem_addr, 0);
    chk("midrst_wdata", imem_wdata, 0);
    chk("midrst_done", done, 0);
    tick(2);
    rst = 1'b1;
    tick(4);
    chk("midrst_idle", in_ready, 0);
    chk("midrst_no_late_write", weCount, 1);
    chk("midrst_word1", mem[1], 32'h0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    startPulse();
    sendByte(8'h01, 0);
    sendWord(32'h36000000, 0);
    sendByte(8'h36, 0);
    stopValid();
    tick(3);
    chk("csum_ok_done", done, 1);
    chk("csum_ok_error", error, 0);
    startPulse();
    sendByte(8'h01, 0);
    sendWord(32'h36000000, 0);
    sendByte(8'h37, 0);
    stopValid();
    tick(3);
    chk("csum_bad_error", error, 1);
    chk("csum_bad_done", done, 0);
    chk("csum_bad_cpu_hold", cpu_hold, 1);
    startPulse();
    #1 chk("csum_err_clear", error, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
